// File: rtl/lsu_store_buffer.sv
// Load/store unit with a FIFO store buffer in front of dmem; loads are answered one cycle after acceptance.
// Define LSU_SB_FORWARD_EN to forward buffered stores to loads; otherwise a matching load stalls until drained.
module lsu_store_buffer #(
    parameter int SB_DEPTH = 4,
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    input  logic                        req_write,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    output logic                        req_ready,
    input  logic                        flush,
    output logic                        resp_valid,
    output logic [DATA_W-1:0]           resp_data,
    output logic [ADDR_W-1:0]           dmem_readAddress,
    input  logic [DATA_W-1:0]           dmem_readData,
    output logic [ADDR_W-1:0]           dmem_writeAddress,
    output logic [DATA_W-1:0]           dmem_writeData,
    output logic                        dmem_writeEnable,
    output logic [$clog2(SB_DEPTH):0]   sb_count,
    output logic                        sb_empty
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
    logic [DATA_W-1:0] sb_data_q [SB_DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;

    logic [SB_DEPTH-1:0] match;
    logic [PTR_W-1:0]    scan_idx;
    logic                fwd_hit;
    logic [DATA_W-1:0]   fwd_data;
    logic                is_load, load_stall, full, drain;
    logic                accept, st_acc, ld_acc;

    // An entry is live when its distance from head is below the current count.
    generate
        for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_match
            logic [PTR_W-1:0] age;
            assign age       = PTR_W'(gi) - head_q;
            assign match[gi] = ({1'b0, age} < count_q) && (sb_addr_q[gi] == req_addr);
        end
    endgenerate

    // Scan oldest to youngest so the youngest matching store is the one kept.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        scan_idx = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            scan_idx = head_q + PTR_W'(k);
            if (match[scan_idx]) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data_q[scan_idx];
            end
        end
    end

    assign is_load = req_valid & ~req_write;
    assign full    = (count_q == CNT_W'(SB_DEPTH));

`ifdef LSU_SB_FORWARD_EN
    assign load_stall = 1'b0;
`else
    assign load_stall = is_load & fwd_hit;
`endif

    // Reset suppresses the drain so buffered stores never reach dmem.
    assign drain     = ~reset & (count_q != '0) & (~req_valid | full | flush | load_stall);
    assign req_ready = ~flush & ~load_stall;
    assign accept    = req_valid & req_ready & ~reset;
    assign st_acc    = accept & req_write;
    assign ld_acc    = accept & ~req_write;

    always_comb begin
        head_d       = head_q + PTR_W'(drain);
        tail_d       = tail_q + PTR_W'(st_acc);
        count_d      = count_q + CNT_W'(st_acc) - CNT_W'(drain);
        resp_valid_d = ld_acc;
        resp_data_d  = resp_data_q;
        if (ld_acc) begin
            resp_data_d = fwd_hit ? fwd_data : dmem_readData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (st_acc) begin
            sb_addr_q[tail_q] <= req_addr;
            sb_data_q[tail_q] <= req_wdata;
        end
    end

    assign resp_valid        = resp_valid_q;
    assign resp_data         = resp_data_q;
    assign dmem_readAddress  = req_addr;
    assign dmem_writeAddress = sb_addr_q[head_q];
    assign dmem_writeData    = sb_data_q[head_q];
    assign dmem_writeEnable  = drain;
    assign sb_count          = count_q;
    assign sb_empty          = (count_q == '0);

endmodule
